handshake_downsizer: RTL and testbench
======================================

Name: handshake_downsizer

Overview:
- Valid/ready width converter placed directly downstream of a handshake DFF slice.
- Accepts one IN_WIDTH word per input handshake and emits it as up to RATIO narrower OUT_WIDTH beats, least-significant sub-word first.
- Used where a 64-bit pipeline feeds a narrower consumer, e.g. a 16-bit bus or debug port.
- Fully registered output. Zero-bubble between consecutive input words.

Parameters:
- IN_WIDTH, 64: input word width in bits.
- OUT_WIDTH, 16: output beat width in bits. IN_WIDTH must be an integer multiple of OUT_WIDTH.
- RATIO, IN_WIDTH/OUT_WIDTH: sub-words per input word. Derived; must be >= 2.
- CW, $clog2(RATIO): width of the beat-count and index fields. Derived.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- data_i  in  IN_WIDTH  input word.
- beats_i  in  CW  number of valid sub-words minus one (0 means 1 beat, RATIO-1 means RATIO beats).
- valid_i  in  1  input word valid.
- ready_o  out  1  block can accept an input word this cycle.
- data_o  out  OUT_WIDTH  current output sub-word.
- last_o  out  1  current beat is the final sub-word of its input word.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the beat.

Behaviour:
- Reset (rst_ni low, asynchronous assert, synchronous deassert by the system):
  - valid_o=0, last_o=0, internal index idx=0, stored count cnt=0.
  - data_o is not reset; its value is don't-care while valid_o=0.
- State:
  - Holding register hold[IN_WIDTH].
  - idx[CW] points to the current sub-word.
  - cnt[CW] is the latched beats_i.
  - valid_o doubles as the busy flag.
- Output mapping, registered:
  - data_o = hold[idx*OUT_WIDTH +: OUT_WIDTH].
  - last_o = valid_o & (idx==cnt).
- Input readiness: ready_o = !valid_o | (ready_i & last_o). It is combinational from ready_i, the same rule as the upstream slice.
- Load (valid_i & ready_o):
  - hold<=data_i, cnt<=beats_i, idx<=0, valid_o<=1.
  - The first sub-word is presented the next cycle, so latency is 1 cycle.
- Advance (valid_o & ready_i & !last_o): idx<=idx+1; hold and cnt unchanged.
- Finish (valid_o & ready_i & last_o):
  - If valid_i is also high, this is a simultaneous load: the new word is loaded the same edge, with no idle cycle.
  - Otherwise valid_o<=0 and idx<=0.
- Stall: when valid_o=1 and ready_i=0, data_o, last_o, idx and hold hold their values.
- Downstream may not see data change while valid_o=1 and ready_i=0 (AXI-style stability).
- Sub-words above index cnt are never emitted, and their contents are ignored.
- idx never exceeds cnt, so no wrap-around past RATIO-1 occurs.
- valid_i is not required to be stable. The block only samples on handshake.
- Reset mid-word discards the remaining sub-words. No beat is emitted after reset until a new load.
- Throughput: N+1 beats per input word (N = beats_i) at one beat per cycle when ready_i=1 continuously.

Test Plan:
1. Reset: hold rst_ni=0 with valid_i=1 -> valid_o=0, ready_o=1. Release, drive data_i=64'h4444_3333_2222_1111, beats_i=3 -> next cycle data_o=16'h1111, last_o=0.
2. Full word, ready_i=1: same input -> beats 1111, 2222, 3333, 4444 on four consecutive cycles; last_o=1 only on 4444; ready_o=1 only in that final cycle.
3. Partial word: data_i=64'hDEAD_BEEF_CAFE_0001, beats_i=1 -> exactly two beats, 0001 then CAFE (last_o=1); BEEF and DEAD are never emitted.
4. Back-to-back: words A (beats_i=0) and B (beats_i=1) offered continuously with ready_i=1 -> beats A0, B0, B1 on three consecutive cycles with valid_o never dropping.
5. Backpressure: ready_i=0 for 3 cycles while beat 2222 is presented -> data_o, last_o and valid_o stable, ready_o=0. Release -> 3333 follows on the next cycle.
6. Async reset mid-word: assert rst_ni=0 between clock edges while beat 2222 is presented -> valid_o drops immediately. After release with valid_i=0 -> no further beats.

Source files
------------

// File: rtl/handshake_downsizer_if.sv
// Valid/ready bundle for the downsizer: wide word in on one side, narrow beats out on the other.
// slave is the converter's view; master is the view of whatever drives the word and sinks the beats.
interface handshake_downsizer_if #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CW    = $clog2(RATIO);

    logic [IN_WIDTH-1:0]  data_i;
    logic [CW-1:0]        beats_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [OUT_WIDTH-1:0] data_o;
    logic                 last_o;
    logic                 valid_o;
    logic                 ready_i;

    modport slave (
        input  data_i,
        input  beats_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output data_o,
        output last_o,
        output valid_o
    );

    modport master (
        output data_i,
        output beats_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  data_o,
        input  last_o,
        input  valid_o
    );
endinterface

// File: rtl/handshake_downsizer.sv
// Splits one IN_WIDTH word into beats_i+1 OUT_WIDTH beats, LS sub-word first; 1-cycle latency, registered outputs.
// Backpressure: outputs hold while ready_i=0; ready_o = !valid_o | (ready_i & last_o), so a new word loads on the final beat.
module handshake_downsizer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    handshake_downsizer_if.slave bus
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CW    = $clog2(RATIO);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  idx_q, idx_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           last_q, last_d;
    logic [RATIO-1:0][OUT_WIDTH-1:0] hold_q, hold_d;
    logic [OUT_WIDTH-1:0]           dat_q, dat_d;
    logic [CW-1:0]                  idx_inc;
    logic                           busy;
    logic                           load;
    logic                           advance;
    logic                           finish;

    assign busy    = (state_q == ST_BUSY);
    assign idx_inc = idx_q + CW'(1);

    assign bus.ready_o = !busy | (bus.ready_i & last_q);
    assign load        = bus.valid_i & bus.ready_o;
    assign advance     = busy & bus.ready_i & !last_q;
    assign finish      = busy & bus.ready_i & last_q;

    // Load wins over finish: that is the zero-bubble hand-over between words.
    // The next beat is selected here so data_o comes straight from a flop.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        hold_d  = hold_q;
        dat_d   = dat_q;
        if (load) begin
            state_d = ST_BUSY;
            idx_d   = '0;
            cnt_d   = bus.beats_i;
            last_d  = (bus.beats_i == '0);
            hold_d  = bus.data_i;
            dat_d   = bus.data_i[OUT_WIDTH-1:0];
        end else if (advance) begin
            idx_d  = idx_inc;
            last_d = (idx_inc == cnt_q);
            dat_d  = hold_q[idx_inc];
        end else if (finish) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Datapath is qualified by valid_o, so it carries no reset.
    always_ff @(posedge clk_i) begin
        hold_q <= hold_d;
        dat_q  <= dat_d;
    end

    assign bus.valid_o = busy;
    assign bus.last_o  = last_q;
    assign bus.data_o  = dat_q;
endmodule

// File: tb/tb_handshake_downsizer.sv
// Scoreboard bench for handshake_downsizer: beats queued when a word is offered, popped as beats are accepted.
module tb_handshake_downsizer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   beats_seen = 0;
    logic [16:0] sbq[$];

    handshake_downsizer_if #(.IN_WIDTH(64), .OUT_WIDTH(16)) bus ();

    handshake_downsizer #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [16:0] e;
        if (rst_n && bus.valid_o && bus.ready_i) begin
            beats_seen++;
            if (sbq.size() == 0) begin
                chk("extra_beat", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("beat_dat", bus.data_o, e[15:0]);
                chk("beat_last", bus.last_o, e[16]);
            end
        end
    end

    // Offers a word and returns just after the accepting edge, valid_i still high.
    task automatic offer(input logic [63:0] d, input logic [1:0] b, output int waits);
        logic acc;
        logic [63:0] dv;
        dv = d;
        bus.data_i  = d;
        bus.beats_i = b;
        bus.valid_i = 1'b1;
        for (int k = 0; k <= int'(b); k++)
            sbq.push_back({(k == int'(b)), dv[k*16 +: 16]});
        acc   = 1'b0;
        waits = 0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = bus.ready_o;
            @(posedge clk);
            #1;
            waits++;
        end
        if (!acc) chk("offer_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int b0;
        rst_n       = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i  = 64'h4444_3333_2222_1111;
        bus.beats_i = 2'd3;
        bus.ready_i = 1'b1;

        // Reset with valid_i high
        @(negedge clk);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_last", bus.last_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full word at full rate
        offer(64'h4444_3333_2222_1111, 2'd3, w);
        bus.valid_i = 1'b0;
        chk("first_wait", w, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("first_dat", bus.data_o, 16'h1111);
            chk("full_valid", bus.valid_o, 1);
            chk("full_last", bus.last_o, (i == 3));
            chk("full_ready", bus.ready_o, (i == 3));
        end
        @(negedge clk);
        chk("full_idle", bus.valid_o, 0);
        @(posedge clk);
        #1;

        // Partial word: upper sub-words never emitted
        offer(64'hDEAD_BEEF_CAFE_0001, 2'd1, w);
        bus.valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("part_valid", bus.valid_o, 1);
            chk("part_last", bus.last_o, (i == 1));
        end
        @(negedge clk);
        chk("part_idle", bus.valid_o, 0);
        @(posedge clk);
        #1;

        // Back-to-back words, no idle cycle
        b0 = beats_seen;
        offer(64'h9999_8888_7777_A0A0, 2'd0, w);
        offer(64'h5555_6666_B1B1_B0B0, 2'd1, w);
        chk("b2b_wait", w, 1);
        bus.valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_b0_valid", bus.valid_o, 1);
        chk("b2b_b0_dat", bus.data_o, 16'hB0B0);
        @(negedge clk);
        chk("b2b_b1_valid", bus.valid_o, 1);
        chk("b2b_b1_last", bus.last_o, 1);
        @(negedge clk);
        chk("b2b_idle", bus.valid_o, 0);
        @(posedge clk);
        #1;
        chk("b2b_beats", beats_seen - b0, 3);

        // Backpressure on beat 2222
        offer(64'h4444_3333_2222_1111, 2'd3, w);
        bus.valid_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 bus.ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_dat", bus.data_o, 16'h2222);
            chk("stall_last", bus.last_o, 0);
            chk("stall_valid", bus.valid_o, 1);
            chk("stall_ready", bus.ready_o, 0);
        end
        @(posedge clk);
        #1 bus.ready_i = 1'b1;
        @(negedge clk);
        chk("release_dat", bus.data_o, 16'h2222);
        @(negedge clk);
        chk("post_stall_dat", bus.data_o, 16'h3333);
        @(negedge clk);
        @(negedge clk);
        chk("stall_idle", bus.valid_o, 0);
        @(posedge clk);
        #1;

        // Asynchronous reset while 2222 is presented
        offer(64'h4444_3333_2222_1111, 2'd3, w);
        bus.valid_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.valid_o, 0);
        chk("arst_ready", bus.ready_o, 1);
        chk("arst_last", bus.last_o, 0);
        sbq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_idle", bus.valid_o, 0);
        end

        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
